// File: rtl/tcp_buf_idx_sched_if.sv
// Request/response bundle between the app-pointer NoC interface and the TCP buffer-index scheduler.
// The master side raises requests and consumes responses; the slave side is the scheduler.
interface tcp_buf_idx_sched_if #(
  parameter int unsigned FLOWID_W = 8,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned BUF_W    = 98
);
  logic                      init_val;
  logic                      init_rdy;
  logic [FLOWID_W-1:0]       init_flowid;

  logic                      get_val;
  logic                      get_rdy;
  logic [FLOWID_W-1:0]       get_flowid;

  logic                      adj_val;
  logic                      adj_rdy;
  logic [FLOWID_W-1:0]       adj_flowid;
  logic [IDX_W-1:0]          adj_old_idx;

  logic                      resp_val;
  logic                      resp_rdy;
  logic [FLOWID_W-1:0]       resp_flowid;
  logic [BUF_W+IDX_W-1:0]    resp_buf;

  logic                      adj_done_val;
  logic                      adj_done_stale;

  modport master (
    output init_val, init_flowid,
    output get_val, get_flowid,
    output adj_val, adj_flowid, adj_old_idx,
    output resp_rdy,
    input  init_rdy, get_rdy, adj_rdy,
    input  resp_val, resp_flowid, resp_buf,
    input  adj_done_val, adj_done_stale
  );

  modport slave (
    input  init_val, init_flowid,
    input  get_val, get_flowid,
    input  adj_val, adj_flowid, adj_old_idx,
    input  resp_rdy,
    output init_rdy, get_rdy, adj_rdy,
    output resp_val, resp_flowid, resp_buf,
    output adj_done_val, adj_done_stale
  );
endinterface

// File: rtl/tcp_buf_idx_sched.sv
// Serialises flow-init, get-buffer and adjust-idx requests onto the per-flow idx table and the
// buffer-descriptor table (both 1-cycle-read RAMs). One operation is outstanding at a time.
module tcp_buf_idx_sched #(
  parameter int unsigned FLOWID_W = 8,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned BUF_W    = 98
) (
  input  logic                      clk,
  input  logic                      rst,
  tcp_buf_idx_sched_if.slave        req,

  output logic                      idx_rd_val,
  output logic [FLOWID_W-1:0]       idx_rd_addr,
  input  logic [IDX_W-1:0]          idx_rd_data,

  output logic                      idx_wr_val,
  output logic [FLOWID_W-1:0]       idx_wr_addr,
  output logic [IDX_W-1:0]          idx_wr_data,

  output logic                      buf_rd_val,
  output logic [FLOWID_W+IDX_W-2:0] buf_rd_addr,
  input  logic [BUF_W-1:0]          buf_rd_data
);

  typedef enum logic [2:0] {
    StIdle,
    StGetIdx,
    StGetBuf,
    StResp,
    StAdjCmp
  } state_e;

  typedef enum logic {
    GrantGet,
    GrantAdj
  } grant_e;

  state_e                   state_q, state_d;
  grant_e                   last_grant_q, last_grant_d;
  logic [FLOWID_W-1:0]      flowid_q, flowid_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         old_idx_q, old_idx_d;
  logic [FLOWID_W-1:0]      resp_flowid_q, resp_flowid_d;
  logic [BUF_W+IDX_W-1:0]   resp_buf_q, resp_buf_d;

  logic init_rdy, get_rdy, adj_rdy;
  logic init_fire, get_fire, adj_fire;
  logic adj_done_val, adj_done_stale;
  logic idx_match;

  // Arbitration. Init always wins; otherwise round-robin between get and adj. With nothing or
  // both valid the round-robin choice holds rdy, so exactly one rdy is high in every idle cycle.
  always_comb begin
    init_rdy = 1'b0;
    get_rdy  = 1'b0;
    adj_rdy  = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (req.init_val) begin
        init_rdy = 1'b1;
      end else if (req.get_val != req.adj_val) begin
        get_rdy = req.get_val;
        adj_rdy = req.adj_val;
      end else if (last_grant_q == GrantAdj) begin
        get_rdy = 1'b1;
      end else begin
        adj_rdy = 1'b1;
      end
    end
  end

  assign init_fire = init_rdy & req.init_val;
  assign get_fire  = get_rdy & req.get_val;
  assign adj_fire  = adj_rdy & req.adj_val;
  assign idx_match = (idx_rd_data == old_idx_q);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    flowid_d       = flowid_q;
    idx_d          = idx_q;
    old_idx_d      = old_idx_q;
    resp_flowid_d  = resp_flowid_q;
    resp_buf_d     = resp_buf_q;
    idx_rd_val     = 1'b0;
    idx_rd_addr    = '0;
    idx_wr_val     = 1'b0;
    idx_wr_addr    = '0;
    idx_wr_data    = '0;
    buf_rd_val     = 1'b0;
    buf_rd_addr    = '0;
    adj_done_val   = 1'b0;
    adj_done_stale = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_fire) begin
          // Init resets the flow's idx in the accept cycle and does not touch the rotation.
          idx_wr_val  = 1'b1;
          idx_wr_addr = req.init_flowid;
          idx_wr_data = '0;
        end else if (get_fire) begin
          idx_rd_val   = 1'b1;
          idx_rd_addr  = req.get_flowid;
          flowid_d     = req.get_flowid;
          last_grant_d = GrantGet;
          state_d      = StGetIdx;
        end else if (adj_fire) begin
          idx_rd_val   = 1'b1;
          idx_rd_addr  = req.adj_flowid;
          flowid_d     = req.adj_flowid;
          old_idx_d    = req.adj_old_idx;
          last_grant_d = GrantAdj;
          state_d      = StAdjCmp;
        end
      end

      StGetIdx: begin
        // The wrap bit selects nothing in the descriptor table.
        idx_d       = idx_rd_data;
        buf_rd_val  = 1'b1;
        buf_rd_addr = {flowid_q, idx_rd_data[IDX_W-2:0]};
        state_d     = StGetBuf;
      end

      StGetBuf: begin
        resp_buf_d    = {buf_rd_data, idx_q};
        resp_flowid_d = flowid_q;
        state_d       = StResp;
      end

      StResp: begin
        if (req.resp_rdy) begin
          state_d = StIdle;
        end
      end

      StAdjCmp: begin
        adj_done_val = 1'b1;
        if (idx_match) begin
          idx_wr_val  = 1'b1;
          idx_wr_addr = flowid_q;
          idx_wr_data = idx_rd_data + IDX_W'(1);
        end else begin
          adj_done_stale = 1'b1;
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= GrantAdj;
      flowid_q      <= '0;
      idx_q         <= '0;
      old_idx_q     <= '0;
      resp_flowid_q <= '0;
      resp_buf_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      flowid_q      <= flowid_d;
      idx_q         <= idx_d;
      old_idx_q     <= old_idx_d;
      resp_flowid_q <= resp_flowid_d;
      resp_buf_q    <= resp_buf_d;
    end
  end

  assign req.init_rdy       = init_rdy;
  assign req.get_rdy        = get_rdy;
  assign req.adj_rdy        = adj_rdy;
  assign req.resp_val       = (state_q == StResp);
  assign req.resp_flowid    = resp_flowid_q;
  assign req.resp_buf       = resp_buf_q;
  assign req.adj_done_val   = adj_done_val;
  assign req.adj_done_stale = adj_done_stale;

`ifndef SYNTHESIS
  a_rdy_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({init_rdy, get_rdy, adj_rdy}));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
    !(idx_rd_val && idx_wr_val));
  a_resp_stable: assert property (@(posedge clk) disable iff (rst)
    (req.resp_val && !req.resp_rdy) |=> (req.resp_val && $stable(req.resp_buf)));
`endif

endmodule

// File: tb/tb_tcp_buf_idx_sched.sv
// Self-checking bench for tcp_buf_idx_sched: RAM models, a reference idx table and scoreboards
// for get responses, descriptor addresses and adjust outcomes.
module tb_tcp_buf_idx_sched;
  localparam int unsigned FLOWID_W = 4;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned BUF_W    = 98;
  localparam int unsigned BA_W     = FLOWID_W + IDX_W - 1;
  localparam int unsigned SNAP_W   = FLOWID_W + BUF_W + IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcp_buf_idx_sched_if #(.FLOWID_W(FLOWID_W), .IDX_W(IDX_W), .BUF_W(BUF_W)) bus ();

  logic                idx_rd_val, idx_wr_val, buf_rd_val;
  logic [FLOWID_W-1:0] idx_rd_addr, idx_wr_addr;
  logic [IDX_W-1:0]    idx_rd_data, idx_wr_data;
  logic [BA_W-1:0]     buf_rd_addr;
  logic [BUF_W-1:0]    buf_rd_data;

  tcp_buf_idx_sched #(.FLOWID_W(FLOWID_W), .IDX_W(IDX_W), .BUF_W(BUF_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (bus),
    .idx_rd_val  (idx_rd_val),
    .idx_rd_addr (idx_rd_addr),
    .idx_rd_data (idx_rd_data),
    .idx_wr_val  (idx_wr_val),
    .idx_wr_addr (idx_wr_addr),
    .idx_wr_data (idx_wr_data),
    .buf_rd_val  (buf_rd_val),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data)
  );

  logic [IDX_W-1:0] idx_mem   [2**FLOWID_W];
  logic [BUF_W-1:0] buf_mem   [2**BA_W];
  logic [IDX_W-1:0] model_idx [2**FLOWID_W];

  always @(posedge clk) begin
    if (idx_wr_val) idx_mem[idx_wr_addr] <= idx_wr_data;
    if (idx_rd_val) idx_rd_data <= idx_mem[idx_rd_addr];
    if (buf_rd_val) buf_rd_data <= buf_mem[buf_rd_addr];
  end

  typedef struct packed {
    logic                stale;
    logic [FLOWID_W-1:0] flow;
    logic [IDX_W-1:0]    wdata;
  } adj_t;

  logic [SNAP_W-1:0] resp_q  [$];
  logic [BA_W-1:0]   baddr_q [$];
  adj_t              adj_q   [$];
  bit                grant_log [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int get_acc_cyc = 0;
  int adj_acc_cyc = 0;
  int n_rr = 0;
  int n_init = 0;
  bit model_last_adj = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    logic              init_fire, get_fire, adj_fire;
    logic              prev_rv, prev_rr;
    logic [SNAP_W-1:0] prev_snap;
    logic [FLOWID_W-1:0] f;
    logic [IDX_W-1:0]  cur;
    logic [BA_W-1:0]   ba;
    adj_t              a;
    prev_rv = 1'b0;
    prev_rr = 1'b0;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 1'b0;
      end else begin
        init_fire = bus.init_val && bus.init_rdy;
        get_fire  = bus.get_val && bus.get_rdy;
        adj_fire  = bus.adj_val && bus.adj_rdy;
        check_eq("rdy_onehot", 128'($countones({bus.init_rdy, bus.get_rdy, bus.adj_rdy}) <= 1), 1);
        check_eq("rd_wr_excl", 128'(idx_rd_val && idx_wr_val), 0);
        if (bus.init_val && (bus.get_rdy || bus.adj_rdy)) check_eq("init_prio", 128'(bus.init_rdy), 1);

        if (init_fire) begin
          n_init++;
          model_idx[bus.init_flowid] = '0;
          check_eq("init_wr", {idx_wr_val, idx_wr_addr, idx_wr_data},
                   {1'b1, bus.init_flowid, {IDX_W{1'b0}}});
        end
        if ((get_fire || adj_fire) && bus.get_val && bus.adj_val && !bus.init_val)
          check_eq("rr_grant", 128'(get_fire), 128'(model_last_adj));
        if (get_fire) begin
          f   = bus.get_flowid;
          cur = model_idx[f];
          ba  = {f, cur[IDX_W-2:0]};
          resp_q.push_back({f, buf_mem[ba], cur});
          baddr_q.push_back(ba);
          check_eq("get_rd", {idx_rd_val, idx_rd_addr}, {1'b1, f});
          get_acc_cyc = cyc;
          model_last_adj = 1'b0;
          grant_log.push_back(1'b1);
          n_rr++;
        end
        if (adj_fire) begin
          f   = bus.adj_flowid;
          cur = model_idx[f];
          a.stale = (cur != bus.adj_old_idx);
          a.flow  = f;
          a.wdata = cur + IDX_W'(1);
          adj_q.push_back(a);
          if (!a.stale) model_idx[f] = a.wdata;
          check_eq("adj_rd", {idx_rd_val, idx_rd_addr}, {1'b1, f});
          adj_acc_cyc = cyc;
          model_last_adj = 1'b1;
          grant_log.push_back(1'b0);
          n_rr++;
        end

        if (buf_rd_val) begin
          if (baddr_q.size() == 0) check_eq("buf_rd_spurious", 128'(buf_rd_val), 0);
          else check_eq("buf_rd_addr", buf_rd_addr, baddr_q.pop_front());
        end

        if (bus.resp_val && !prev_rv) check_eq("resp_latency", cyc - get_acc_cyc, 3);
        if (prev_rv && !prev_rr)
          check_eq("resp_hold", {bus.resp_val, bus.resp_flowid, bus.resp_buf}, {1'b1, prev_snap});
        if (bus.resp_val && bus.resp_rdy) begin
          if (resp_q.size() == 0) check_eq("resp_spurious", 128'(bus.resp_val), 0);
          else check_eq("resp_data", {bus.resp_flowid, bus.resp_buf}, resp_q.pop_front());
        end

        if (bus.adj_done_val) begin
          if (adj_q.size() == 0) begin
            check_eq("adj_spurious", 128'(bus.adj_done_val), 0);
          end else begin
            a = adj_q.pop_front();
            check_eq("adj_latency", cyc - adj_acc_cyc, 1);
            check_eq("adj_stale", 128'(bus.adj_done_stale), 128'(a.stale));
            check_eq("adj_wr_val", 128'(idx_wr_val), 128'(!a.stale));
            if (!a.stale) check_eq("adj_wr", {idx_wr_addr, idx_wr_data}, {a.flow, a.wdata});
          end
        end else if (!init_fire) begin
          check_eq("wr_spurious", 128'(idx_wr_val), 0);
        end

        prev_rv   = bus.resp_val;
        prev_rr   = bus.resp_rdy;
        prev_snap = {bus.resp_flowid, bus.resp_buf};
      end
    end
  end

  task automatic wait_rdy(input int kind);
    logic r;
    int   g;
    g = 0;
    r = 1'b0;
    forever begin
      @(negedge clk);
      r = (kind == 0) ? bus.init_rdy : (kind == 1) ? bus.get_rdy : bus.adj_rdy;
      if (r || g >= 100) break;
      g++;
    end
    if (!r) check_eq("accept_timeout", 128'(r), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic op_init(input logic [FLOWID_W-1:0] f);
    bus.init_val = 1'b1;
    bus.init_flowid = f;
    wait_rdy(0);
    bus.init_val = 1'b0;
  endtask

  task automatic op_get(input logic [FLOWID_W-1:0] f);
    bus.get_val = 1'b1;
    bus.get_flowid = f;
    wait_rdy(1);
    bus.get_val = 1'b0;
  endtask

  task automatic op_adj(input logic [FLOWID_W-1:0] f, input logic [IDX_W-1:0] old);
    bus.adj_val = 1'b1;
    bus.adj_flowid = f;
    bus.adj_old_idx = old;
    wait_rdy(2);
    bus.adj_val = 1'b0;
  endtask

  task automatic drain();
    int g;
    for (g = 0; g < 200; g++) begin
      @(posedge clk);
      #1;
      if (resp_q.size() == 0 && adj_q.size() == 0 && baddr_q.size() == 0) break;
    end
    check_eq("drain", resp_q.size() + adj_q.size() + baddr_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp_val();
    int g;
    for (g = 0; g < 50; g++) begin
      @(negedge clk);
      if (bus.resp_val) break;
    end
    check_eq("resp_val_timeout", 128'(bus.resp_val), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int start, init_start;
    bit exp_first, init_issued;
    for (int i = 0; i < 2**FLOWID_W; i++) begin
      idx_mem[i] = '0;
      model_idx[i] = '0;
    end
    for (int i = 0; i < 2**BA_W; i++) buf_mem[i] = {64'hA000_0000 + 64'(i), 17'(i * 3), 17'(i + 7)};
    buf_mem[{4'd5, 3'd0}] = {64'h1000, 17'h40, 17'h40};
    idx_mem[9] = 4'd5;
    model_idx[9] = 4'd5;
    bus.init_val = 1'b0; bus.init_flowid = '0;
    bus.get_val = 1'b0;  bus.get_flowid = '0;
    bus.adj_val = 1'b0;  bus.adj_flowid = '0; bus.adj_old_idx = '0;
    bus.resp_rdy = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vals", {bus.resp_val, bus.adj_done_val, bus.adj_done_stale, idx_rd_val,
                          idx_wr_val, buf_rd_val}, 0);
    check_eq("rst_rdy", {bus.init_rdy, bus.get_rdy, bus.adj_rdy}, 0);
    check_eq("rst_resp", {bus.resp_flowid, bus.resp_buf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_get_rdy", 128'(bus.get_rdy), 1);
    @(posedge clk);
    #1;

    // Init + get with backpressure
    op_init(4'd5);
    bus.resp_rdy = 1'b0;
    op_get(4'd5);
    wait_resp_val();
    check_eq("t2_resp", bus.resp_buf, {64'h1000, 17'h40, 17'h40, 4'd0});
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    bus.resp_rdy = 1'b1;
    drain();

    // Adjust match then stale
    op_adj(4'd5, 4'd0);
    op_adj(4'd5, 4'd0);
    drain();
    check_eq("t3_idx", idx_mem[5], 1);

    // Back-to-back adjust then get on the same flow
    op_adj(4'd5, 4'd1);
    op_get(4'd5);
    drain();
    check_eq("t6_idx", idx_mem[5], 2);

    // Wrap
    op_init(4'd3);
    for (int i = 0; i < 8; i++) op_adj(4'd3, IDX_W'(i));
    op_get(4'd3);
    drain();
    check_eq("t4_idx8", idx_mem[3], 8);
    for (int i = 8; i < 16; i++) op_adj(4'd3, IDX_W'(i));
    drain();
    check_eq("t4_idx0", idx_mem[3], 0);
    op_get(4'd3);
    drain();

    // Round-robin with concurrent init
    grant_log.delete();
    start = n_rr;
    init_start = n_init;
    exp_first = model_last_adj;
    init_issued = 1'b0;
    bus.get_flowid = 4'd6;
    bus.adj_flowid = 4'd6;
    bus.adj_old_idx = 4'd9;
    bus.get_val = 1'b1;
    bus.adj_val = 1'b1;
    for (int g = 0; g < 400; g++) begin
      @(posedge clk);
      #1;
      if (init_issued && n_init > init_start) bus.init_val = 1'b0;
      if (n_rr >= start + 4) break;
      if (n_rr >= start + 1 && !init_issued) begin
        bus.init_val = 1'b1;
        bus.init_flowid = 4'd9;
        init_issued = 1'b1;
      end
    end
    bus.get_val = 1'b0;
    bus.adj_val = 1'b0;
    bus.init_val = 1'b0;
    drain();
    check_eq("t5_init_cnt", n_init - init_start, 1);
    check_eq("t5_init_idx", idx_mem[9], 0);
    check_eq("t5_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq("t5_alt", 128'(grant_log[i]), 128'((i % 2 == 0) ? exp_first : !exp_first));

    // Async reset while a response is stalled
    bus.resp_rdy = 1'b0;
    op_get(4'd7);
    wait_resp_val();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t1_async_vals", {bus.resp_val, bus.adj_done_val, idx_rd_val, idx_wr_val,
                               buf_rd_val, bus.init_rdy, bus.get_rdy, bus.adj_rdy}, 0);
    check_eq("t1_async_resp", {bus.resp_flowid, bus.resp_buf}, 0);
    resp_q.delete();
    baddr_q.delete();
    adj_q.delete();
    bus.resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t1_idle_rdy", 128'(bus.get_rdy), 1);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
